// File: rtl/chrom_serial_loader.sv
// Serial-to-parallel chromosome loader: shifts bits into a shadow register and commits them atomically to the LE grid.
// Optional feature: define CHROM_PARITY_EN to append an even-parity bit to each frame.
module chrom_serial_loader #(
  parameter int ROW   = 4,
  parameter int COL   = 4,
  parameter int OUT   = 4,
  parameter int SEL_W = $clog2(ROW*COL)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic                             ser_valid,
  input  logic                             ser_data,
  output logic                             ser_ready,
  output logic                             busy,
  output logic                             cfg_done,
  output logic                             cfg_valid,
  output logic                             cfg_err,
  output logic [ROW-1:0][COL-1:0][15:0]    saidas_LE,
  output logic [OUT-1:0][SEL_W-1:0]        out_chrom
);

  localparam int NBITS = ROW*COL*16 + OUT*SEL_W;
`ifdef CHROM_PARITY_EN
  localparam int FRAME = NBITS + 1;
`else
  localparam int FRAME = NBITS;
`endif
  localparam int CW = $clog2(NBITS+2);
  localparam logic [CW-1:0] LAST = CW'(FRAME-1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t           state, state_nx;
  logic [NBITS-1:0] shadow;
  logic [CW-1:0]    count;
  logic             xfer;

  assign ser_ready = (state == LOAD);
  assign busy      = (state != IDLE);
  assign xfer      = ser_valid & ser_ready;

`ifdef CHROM_PARITY_EN
  logic par_acc;
  logic par_bad;
  logic err_q;
  assign cfg_err = err_q;
`else
  assign cfg_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    if (!start && xfer && count == LAST) state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Shadow collects the frame; the active outputs are only ever written as a whole at COMMIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      count     <= '0;
      saidas_LE <= '0;
      out_chrom <= '0;
      cfg_done  <= 1'b0;
      cfg_valid <= 1'b0;
`ifdef CHROM_PARITY_EN
      par_acc   <= 1'b0;
      par_bad   <= 1'b0;
      err_q     <= 1'b0;
`endif
    end else begin
      state    <= state_nx;
      cfg_done <= 1'b0;
`ifdef CHROM_PARITY_EN
      err_q    <= 1'b0;
`endif
      case (state)
        IDLE, LOAD: begin
          if (start) begin
            count <= '0;
`ifdef CHROM_PARITY_EN
            par_acc <= 1'b0;
`endif
          end else if (xfer) begin
            count <= count + 1'b1;
`ifdef CHROM_PARITY_EN
            // The trailing parity bit is checked, never shifted into the shadow.
            if (count == LAST) begin
              par_bad <= par_acc ^ ser_data;
            end else begin
              shadow  <= {shadow[NBITS-2:0], ser_data};
              par_acc <= par_acc ^ ser_data;
            end
`else
            shadow <= {shadow[NBITS-2:0], ser_data};
`endif
          end
        end
        COMMIT: begin
          count <= '0;
`ifdef CHROM_PARITY_EN
          if (par_bad) begin
            err_q <= 1'b1;
          end else begin
            {saidas_LE, out_chrom} <= shadow;
            cfg_done               <= 1'b1;
            cfg_valid              <= 1'b1;
          end
`else
          {saidas_LE, out_chrom} <= shadow;
          cfg_done               <= 1'b1;
          cfg_valid              <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chrom_serial_loader.sv
// Scoreboard bench for chrom_serial_loader: random and directed frames, gaps, restarts, resets.
// Honours CHROM_PARITY_EN when the design is built with it.
module tb_chrom_serial_loader;

  localparam int ROW   = 4;
  localparam int COL   = 4;
  localparam int OUT   = 4;
  localparam int SEL_W = 4;
  localparam int NBITS = ROW*COL*16 + OUT*SEL_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic ser_valid = 1'b0;
  logic ser_data = 1'b0;
  logic ser_ready, busy, cfg_done, cfg_valid, cfg_err;
  logic [ROW-1:0][COL-1:0][15:0] saidas_LE;
  logic [OUT-1:0][SEL_W-1:0]     out_chrom;

  chrom_serial_loader #(.ROW(ROW), .COL(COL), .OUT(OUT), .SEL_W(SEL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .ser_valid(ser_valid), .ser_data(ser_data),
    .ser_ready(ser_ready), .busy(busy), .cfg_done(cfg_done), .cfg_valid(cfg_valid),
    .cfg_err(cfg_err), .saidas_LE(saidas_LE), .out_chrom(out_chrom)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NBITS-1:0] frame;
    bit               bad;
    int               cyc;
  } exp_t;

  exp_t             exp_q[$];
  logic [NBITS-1:0] model_active = '0;
  logic             model_valid  = 1'b0;
  int               cyc = 0;
  int               total = 0;
  int               bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [NBITS-1:0] act, input logic [NBITS-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every commit/error pulse is matched against the oldest expected frame.
  always @(negedge clk) begin
    if (!rst) begin
      if (cfg_done || cfg_err) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_pulse", {cfg_done, cfg_err}, 2'b00);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checkOutput("done_latency", cyc, e.cyc + 1);
          checkOutput("done_flag", cfg_done, !e.bad);
          checkOutput("err_flag", cfg_err, e.bad);
          if (!e.bad) begin
            model_active = e.frame;
            model_valid  = 1'b1;
          end
        end
      end else if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 1) begin
        checkOutput("missing_pulse", 0, 1);
        void'(exp_q.pop_front());
      end
      checkOutput("active_outputs", {saidas_LE, out_chrom}, model_active);
      checkOutput("cfg_valid", cfg_valid, model_valid);
    end
  end

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic sendBit(input logic b, output int acc_cyc);
    int  n;
    bit  rdy;
    ser_valid = 1'b1;
    ser_data  = b;
    n = 0;
    acc_cyc = -1;
    while (acc_cyc < 0 && n < 50) begin
      rdy = ser_ready;
      @(posedge clk);
      #1;
      if (rdy) acc_cyc = cyc;
      n++;
    end
    ser_valid = 1'b0;
    if (acc_cyc < 0) checkOutput("bit_accept_timeout", 0, 1);
  endtask

  // Sends one full frame MSB first; optional gap after bit gap_at and a deliberately wrong parity bit.
  task automatic applyStimulus(input logic [NBITS-1:0] frm, input int gap_at, input int gap_len,
                               input bit bad_par, input bit do_start);
    int   acc;
    exp_t e;
    if (do_start) startPulse();
    for (int i = NBITS-1; i >= 0; i--) begin
      sendBit(frm[i], acc);
      if (NBITS-1-i == gap_at) begin
        repeat (gap_len) begin
          @(posedge clk);
          #1 checkOutput("gap_ready", ser_ready, 1);
        end
      end
    end
`ifdef CHROM_PARITY_EN
    sendBit((^frm) ^ bad_par, acc);
    e.bad = bad_par;
`else
    e.bad = 1'b0;
`endif
    e.frame = frm;
    e.cyc   = acc;
    exp_q.push_back(e);
  endtask

  function automatic logic [NBITS-1:0] randFrame();
    logic [NBITS-1:0] f;
    for (int i = 0; i < NBITS; i++) f[i] = 1'($urandom_range(0, 1));
    return f;
  endfunction

  task automatic waitSettle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [NBITS-1:0] frm3;
  logic [NBITS-1:0] prev;
  int               dummy;

  initial begin
    frm3 = {16'h8000, {(NBITS-32){1'b0}}, 16'h1234};

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {saidas_LE, out_chrom}, '0);
    checkOutput("reset_flags", {ser_ready, busy, cfg_done, cfg_valid, cfg_err}, 5'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // All ones
    applyStimulus({NBITS{1'b1}}, -1, 0, 1'b0, 1'b1);
    waitSettle();
    checkOutput("ones_le00", saidas_LE[0][0], 16'hFFFF);
    checkOutput("ones_oc0", out_chrom[0], 4'hF);

    // Directed placement
    applyStimulus(frm3, -1, 0, 1'b0, 1'b1);
    waitSettle();
    checkOutput("dir_le33", saidas_LE[3][3], 16'h8000);
    checkOutput("dir_le00", saidas_LE[0][0], 16'h0000);
    checkOutput("dir_oc", out_chrom, 16'h1234);
    checkOutput("dir_oc3", out_chrom[3], 4'h1);

    // Random frames with occasional gaps
    for (int k = 0; k < 4; k++) begin
      applyStimulus(randFrame(), $urandom_range(0, NBITS-1), $urandom_range(0, 6), 1'b0, 1'b1);
      waitSettle();
    end

    // Directed frame with a five-cycle gap after bit 100
    applyStimulus(frm3, 100, 5, 1'b0, 1'b1);
    waitSettle();
    checkOutput("gap_le33", saidas_LE[3][3], 16'h8000);
    checkOutput("gap_oc", out_chrom, 16'h1234);

    // Restart after bit 100: partial frame must never reach the outputs
    prev = {saidas_LE, out_chrom};
    startPulse();
    for (int i = 0; i < 101; i++) sendBit(1'($urandom_range(0, 1)), dummy);
    ser_valid = 1'b1;
    ser_data  = 1'b1;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    ser_valid = 1'b0;
    checkOutput("restart_busy", busy, 1);
    checkOutput("restart_hold", {saidas_LE, out_chrom}, prev);
    applyStimulus(randFrame(), -1, 0, 1'b0, 1'b0);
    waitSettle();

`ifdef CHROM_PARITY_EN
    applyStimulus(frm3, -1, 0, 1'b0, 1'b1);
    waitSettle();
    checkOutput("par_ok_le33", saidas_LE[3][3], 16'h8000);
    applyStimulus({NBITS{1'b1}}, -1, 0, 1'b1, 1'b1);
    waitSettle();
    checkOutput("par_bad_hold", out_chrom, 16'h1234);
`endif

    // Asynchronous reset mid-frame
    startPulse();
    for (int i = 0; i < 50; i++) sendBit(1'b1, dummy);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", {saidas_LE, out_chrom}, '0);
    checkOutput("async_rst_flags", {ser_ready, busy, cfg_done, cfg_valid, cfg_err}, 5'b0);
    model_active = '0;
    model_valid  = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Recovery
    applyStimulus(randFrame(), $urandom_range(0, NBITS-1), 3, 1'b0, 1'b1);
    waitSettle();
    checkOutput("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
